// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between two requesters, one op in flight.
// Optional macro ALU_ARB_ILLEGAL_EN adds illegal-opcode rejection and the resp_err port.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req0_op,
  input  logic [3:0]       req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
`ifdef ALU_ARB_ILLEGAL_EN
  output logic             resp_err,
`endif
  output logic [WIDTH-1:0] alu_entr1,
  output logic [WIDTH-1:0] alu_entr2,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_last;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [3:0]         r_op;
  logic               r_id;
  logic               r_resp_valid;
  logic               r_resp_id;
  logic [WIDTH-1:0]   r_resp_result;
  logic               r_resp_zero;
  logic               w_gnt_id;
  logic               w_idle_ok;
  logic               w_hs;
  logic               w_is_branch;
  logic               w_illegal;

  // Round-robin grant; ready only in IDLE and never while reset is asserted.
  always_comb begin
    if (req0_valid && req1_valid) begin
      w_gnt_id = ~r_last;
    end else if (req1_valid) begin
      w_gnt_id = 1'b1;
    end else begin
      w_gnt_id = 1'b0;
    end
    w_idle_ok  = (r_state == IDLE) && rst_n;
    req0_ready = w_idle_ok && req0_valid && !w_gnt_id;
    req1_ready = w_idle_ok && req1_valid && w_gnt_id;
    w_hs       = w_idle_ok && (req0_valid || req1_valid);
  end

  // Decode of the latched opcode.
  always_comb begin
    w_is_branch = (r_op == 4'b0110) || (r_op == 4'b0111) || (r_op == 4'b1111);
`ifdef ALU_ARB_ILLEGAL_EN
    w_illegal   = r_op[3] && (r_op != 4'b1111);
`else
    w_illegal   = 1'b0;
`endif
  end

  // Shared ALU is driven only during EXEC, and not at all for rejected opcodes.
  always_comb begin
    if ((r_state == EXEC) && !w_illegal) begin
      alu_entr1 = r_a;
      alu_entr2 = r_b;
      alu_ctrl  = r_op;
    end else begin
      alu_entr1 = {WIDTH{1'b0}};
      alu_entr2 = {WIDTH{1'b0}};
      alu_ctrl  = 4'b0000;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_hs) begin
          w_next = EXEC;
        end else begin
          w_next = IDLE;
        end
      end
      EXEC: w_next = RESP;
      RESP: begin
        if (resp_ready) begin
          w_next = IDLE;
        end else begin
          w_next = RESP;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Request latch and round-robin pointer; the pointer moves only on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
      r_a    <= {WIDTH{1'b0}};
      r_b    <= {WIDTH{1'b0}};
      r_op   <= 4'b0000;
      r_id   <= 1'b0;
    end else if (w_hs) begin
      r_last <= w_gnt_id;
      r_id   <= w_gnt_id;
      r_a    <= w_gnt_id ? req1_a : req0_a;
      r_b    <= w_gnt_id ? req1_b : req0_b;
      r_op   <= w_gnt_id ? req1_op : req0_op;
    end else begin
      r_last <= r_last;
    end
  end

  // Response registers: captured at the end of EXEC, held until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid  <= 1'b0;
      r_resp_id     <= 1'b0;
      r_resp_result <= {WIDTH{1'b0}};
      r_resp_zero   <= 1'b0;
    end else if (r_state == EXEC) begin
      r_resp_valid  <= 1'b1;
      r_resp_id     <= r_id;
      r_resp_result <= (w_is_branch || w_illegal) ? {WIDTH{1'b0}} : alu_result;
      r_resp_zero   <= w_is_branch && !w_illegal && alu_zero;
    end else if ((r_state == RESP) && resp_ready) begin
      r_resp_valid  <= 1'b0;
    end else begin
      r_resp_valid  <= r_resp_valid;
    end
  end

`ifdef ALU_ARB_ILLEGAL_EN
  logic r_resp_err;

  // Error flag accompanies the response of a rejected opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_err <= 1'b0;
    end else if (r_state == EXEC) begin
      r_resp_err <= w_illegal;
    end else begin
      r_resp_err <= r_resp_err;
    end
  end

  assign resp_err = r_resp_err;
`endif

  assign resp_valid  = r_resp_valid;
  assign resp_id     = r_resp_id;
  assign resp_result = r_resp_result;
  assign resp_zero   = r_resp_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed vectors push expected responses, a monitor pops them.
// Honours ALU_ARB_ILLEGAL_EN when the design is built with it.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        resp_valid, resp_ready, resp_id, resp_zero;
  logic [31:0] resp_result;
  logic        resp_err_s;
  logic [31:0] alu_entr1, alu_entr2, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic exec_q;
  logic hold_q = 1'b0;
  logic        h_id, h_zero;
  logic [31:0] h_res;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_zero(resp_zero),
`ifdef ALU_ARB_ILLEGAL_EN
    .resp_err(resp_err_s),
`endif
    .alu_entr1(alu_entr1), .alu_entr2(alu_entr2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

`ifndef ALU_ARB_ILLEGAL_EN
  assign resp_err_s = 1'b0;
`endif

  // External ALU model; branch ops return junk so result gating is visible.
  always_comb begin
    alu_result = 32'h0;
    alu_zero   = 1'b0;
    case (alu_ctrl)
      4'b0000: begin alu_result = alu_entr1 + alu_entr2; alu_zero = (alu_result == 32'h0); end
      4'b0001: begin alu_result = alu_entr1 - alu_entr2; alu_zero = (alu_result == 32'h0); end
      4'b0100: begin alu_result = alu_entr1 | alu_entr2; alu_zero = (alu_result == 32'h0); end
      4'b0110: begin alu_result = 32'hDEADBEEF; alu_zero = (alu_entr1 == alu_entr2); end
      4'b0111: begin alu_result = 32'hDEADBEEF; alu_zero = (alu_entr1 != alu_entr2); end
      4'b1111: begin alu_result = 32'hDEADBEEF; alu_zero = (alu_entr1 < alu_entr2); end
      default: begin alu_result = alu_entr1 ^ alu_entr2; alu_zero = (alu_result == 32'h0); end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // The cycle after an observed handshake is the EXEC cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exec_q <= 1'b0;
    else        exec_q <= (req0_valid & req0_ready) | (req1_valid & req1_ready);
  end

  // Monitor: pops the scoreboard on each consumed response and watches invariants.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (resp_valid) begin
        chk("ready0_in_resp", {31'b0, req0_ready}, 32'h0);
        chk("ready1_in_resp", {31'b0, req1_ready}, 32'h0);
        if (hold_q) begin
          chk("hold_id", {31'b0, resp_id}, {31'b0, h_id});
          chk("hold_result", resp_result, h_res);
          chk("hold_zero", {31'b0, resp_zero}, {31'b0, h_zero});
        end
        if (resp_ready) begin
          hold_q = 1'b0;
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_resp: actual id=%0d result=%0h required none", resp_id, resp_result);
          end else begin
            m_e = sb.pop_front();
            chk("resp_id", {31'b0, resp_id}, {31'b0, m_e.id});
            chk("resp_result", resp_result, m_e.res);
            chk("resp_zero", {31'b0, resp_zero}, {31'b0, m_e.zero});
`ifdef ALU_ARB_ILLEGAL_EN
            chk("resp_err", {31'b0, resp_err_s}, {31'b0, m_e.err});
`endif
          end
        end else begin
          hold_q = 1'b1;
          h_id   = resp_id;
          h_res  = resp_result;
          h_zero = resp_zero;
        end
      end else begin
        hold_q = 1'b0;
      end
      if (!exec_q) begin
        chk("alu_ctrl_idle", {28'b0, alu_ctrl}, 32'h0);
        chk("alu_entr1_idle", alu_entr1, 32'h0);
      end else if (!resp_valid) begin
        chk("ready_in_exec", {30'b0, req1_ready, req0_ready}, 32'h0);
      end
    end else begin
      hold_q = 1'b0;
    end
  end

  task automatic set_req(input logic id, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    if (id) begin req1_valid = v; req1_a = a; req1_b = b; req1_op = op; end
    else    begin req0_valid = v; req0_a = a; req0_b = b; req0_op = op; end
  endtask

  task automatic wait_grant(input logic id, output logic ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc++;
    end
    chk("grant_timeout", {31'b0, ok}, 32'h1);
  endtask

  task automatic push(input logic id, input logic [31:0] r, input logic z, input logic e);
    exp_t x;
    x.id = id; x.res = r; x.zero = z; x.err = e;
    sb.push_back(x);
  endtask

  // Issue one op; returns #1 into the EXEC cycle.
  task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       input logic [31:0] er, input logic ez, input logic ee);
    logic ok;
    int   cyc;
    @(posedge clk); #1;
    set_req(id, 1'b1, a, b, op);
    wait_grant(id, ok, cyc);
    if (ok) push(id, er, ez, ee);
    @(posedge clk); #1;
    set_req(id, 1'b0, a, b, op);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0 && !resp_valid) break;
      @(negedge clk);
    end
    chk("drain", sb.size(), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   cyc;
    rst_n = 1'b0;
    resp_ready = 1'b1;
    set_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1'b0, 1'b1, 32'd5, 32'd3, 4'b0000);
    #12;
    chk("rst_ready0", {31'b0, req0_ready}, 32'h0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_resp_id", {31'b0, resp_id}, 32'h0);
    chk("rst_resp_result", resp_result, 32'h0);
    chk("rst_resp_zero", {31'b0, resp_zero}, 32'h0);
    chk("rst_alu_ctrl", {28'b0, alu_ctrl}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // single op, granted in the first IDLE cycle, latency N+2
    wait_grant(1'b0, ok, cyc);
    chk("first_idle_grant", cyc, 32'h0);
    if (ok) push(1'b0, 32'd8, 1'b0, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    chk("exec_entr1", alu_entr1, 32'd5);
    chk("exec_entr2", alu_entr2, 32'd3);
    chk("exec_no_valid", {31'b0, resp_valid}, 32'h0);
    @(posedge clk); #1;
    chk("lat_valid_n2", {31'b0, resp_valid}, 32'h1);
    drain();

    // tie from reset, then round-robin with both still requesting
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    set_req(1'b0, 1'b1, 32'd10, 32'd4, 4'b0001);
    set_req(1'b1, 1'b1, 32'h0F, 32'hF0, 4'b0100);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_grant(1'b0, ok, cyc);
    chk("tie_req1_ready", {31'b0, req1_ready}, 32'h0);
    if (ok) push(1'b0, 32'd6, 1'b0, 1'b0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 32'd1, 32'd1, 4'b0000);
    wait_grant(1'b1, ok, cyc);
    chk("rr_req0_ready", {31'b0, req0_ready}, 32'h0);
    if (ok) push(1'b1, 32'hFF, 1'b0, 1'b0);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_grant(1'b0, ok, cyc);
    if (ok) push(1'b0, 32'd2, 1'b0, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drain();

    // branch compares and zero gating for non-branch ops
    issue(1'b1, 32'd7, 32'd7, 4'b0110, 32'h0, 1'b1, 1'b0);
    issue(1'b1, 32'd7, 32'd7, 4'b0111, 32'h0, 1'b0, 1'b0);
    issue(1'b1, 32'd3, 32'd9, 4'b1111, 32'h0, 1'b1, 1'b0);
    issue(1'b0, 32'd4, 32'd4, 4'b0001, 32'h0, 1'b0, 1'b0);
    drain();

    // backpressure with a competing request held high
    resp_ready = 1'b0;
    issue(1'b0, 32'd100, 32'd23, 4'b0001, 32'd77, 1'b0, 1'b0);
    set_req(1'b1, 1'b1, 32'd1, 32'd1, 4'b0000);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, resp_valid}, 32'h1);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    drain();

    // reset during EXEC discards the operation
    issue(1'b1, 32'd2, 32'd2, 4'b0000, 32'd4, 1'b0, 1'b0);
    rst_n = 1'b0;
    sb.delete();
    req0_valid = 1'b1;
    #1;
    chk("mid_rst_ready0", {31'b0, req0_ready}, 32'h0);
    chk("mid_rst_valid", {31'b0, resp_valid}, 32'h0);
    chk("mid_rst_result", resp_result, 32'h0);
    chk("mid_rst_id", {31'b0, resp_id}, 32'h0);
    chk("mid_rst_alu_ctrl", {28'b0, alu_ctrl}, 32'h0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_resp", {31'b0, resp_valid}, 32'h0);
    end

    // opcode in the 1000-1110 range
`ifdef ALU_ARB_ILLEGAL_EN
    issue(1'b0, 32'h0000F0F0, 32'h00000FF0, 4'b1010, 32'h0, 1'b0, 1'b1);
    chk("illegal_alu_ctrl", {28'b0, alu_ctrl}, 32'h0);
    chk("illegal_alu_entr1", alu_entr1, 32'h0);
`else
    issue(1'b0, 32'h0000F0F0, 32'h00000FF0, 4'b1010, 32'h0000FF00, 1'b0, 1'b0);
    chk("op1010_alu_ctrl", {28'b0, alu_ctrl}, 32'hA);
    chk("op1010_alu_entr1", alu_entr1, 32'h0000F0F0);
`endif
    issue(1'b0, 32'd1, 32'd2, 4'b0000, 32'd3, 1'b0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: req0_valid, req1_valid  input  1 each  requester 0/1 presents an operation.
REQ-005 SHALL have ports: req0_ready, req1_ready  output  1 each  requester 0/1 operation accepted this cycle.
REQ-006 SHALL have ports: req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands.
REQ-007 SHALL have ports: req0_op, req1_op  input  4 each  ALU control code.
REQ-008 SHALL have ports: resp_valid  output  1; resp_ready  input  1; resp_id  output  1 (requester index); resp_result  output  WIDTH; resp_zero  output  1.
REQ-009 SHALL have ports to the shared ALU: alu_entr1, alu_entr2  output  WIDTH; alu_ctrl  output  4; alu_result  input  WIDTH; alu_zero  input  1.

Function
REQ-010 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-011 IDLE: SHALL assert readyN for exactly one granted requester with validN high; handshake = validN & readyN; on handshake latch a, b, op, id and go to EXEC.
REQ-012 Arbitration SHALL be round-robin: if both valid, grant the requester not granted last; if one valid, grant it.
REQ-013 EXEC: SHALL drive alu_entr1/alu_entr2/alu_ctrl from latched values for exactly one cycle, capture alu_result and alu_zero at end of cycle, go to RESP.
REQ-014 RESP: SHALL hold resp_valid=1 with stable resp_id/result/zero until resp_valid & resp_ready, then go to IDLE.
REQ-015 Latency SHALL be: handshake in cycle N, EXEC in N+1, resp_valid high from N+2.
REQ-016 readyN SHALL be 0 in EXEC and RESP; no new request accepted until response consumed (one operation in flight).
REQ-017 resp_zero SHALL equal captured alu_zero only for op 0110, 0111, 1111; for all other ops SHALL be 0.
REQ-018 For op 0110, 0111, 1111 resp_result SHALL be 0 (ALU result not meaningful for branch compares).
REQ-019 Outside EXEC, alu_entr1, alu_entr2 SHALL be 0 and alu_ctrl SHALL be 0000.
REQ-020 Requester dropping validN while not granted SHALL have no effect; arbitration re-evaluates every IDLE cycle.
REQ-021 Round-robin pointer SHALL update only on handshake.

Reset
REQ-022 rst_n low SHALL asynchronously force: state IDLE, req0_ready=0, req1_ready=0, resp_valid=0, resp_id=0, resp_result=0, resp_zero=0, latched operands/op 0, last-grant pointer = 1 (requester 0 wins first tie).
REQ-023 Reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response issued after release.
REQ-024 First IDLE cycle after reset release SHALL allow a handshake.

Configuration
REQ-025 Macro ALU_ARB_ILLEGAL_EN SHALL enable illegal-opcode rejection: ops 1000-1110 accepted normally but skip ALU drive in EXEC (alu_ctrl stays 0000), respond with resp_result=0, resp_zero=0, and additional output port resp_err (1 bit, reset 0) =1 with that response.
REQ-026 Without ALU_ARB_ILLEGAL_EN, port resp_err SHALL not exist and all ops SHALL pass to the ALU unchanged.

Verification
REQ-027 Single op: req0 a=5, b=3, op=0000, resp_ready=1 -> resp_valid at N+2, resp_id=0, resp_result=8, resp_zero=0.
REQ-028 Tie: both valid from reset, req0 op=0001 a=10 b=4, req1 op=0100 a=0x0F b=0xF0 -> first resp id=0 result=6, second resp id=1 result=0xFF.
REQ-029 Branch: req1 a=7, b=7, op=0110 -> resp_zero=1, resp_result=0; repeat op=0111 -> resp_zero=0.
REQ-030 Backpressure: resp_ready=0 for 5 cycles after resp_valid -> outputs stable, req0_ready/req1_ready=0 throughout; completes on resp_ready=1.
REQ-031 Reset mid-op: assert rst_n=0 in EXEC -> all outputs reset values; no resp_valid after release until new handshake.
REQ-032 With ALU_ARB_ILLEGAL_EN: req0 op=1010 -> resp_err=1, resp_result=0, alu_ctrl never non-zero; op=0000 next -> resp_err=0.
